// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//   8N1 UART transmitter. A byte is taken on a tx_valid/tx_ready handshake and
//   sent on TxD as a 10-bit frame: start (0), eight data bits LSB first, stop (1).
//   Bit timing comes from a free counter on clk_fpga. Each bit lasts exactly
//   bit_ticks cycles. There is no oversampling and no input buffering.
//
// Parameters
//   clk_freq   system clock frequency in Hz
//   baud_rate  line rate in bit/s
//   bit_ticks  clk cycles per bit (clk_freq/baud_rate, must be >= 2)
//
// Ports
//   clk_fpga  in   system clock; all state changes on its rising edge
//   reset     in   asynchronous, active-high reset
//   tx_data   in   [7:0] byte to send, sampled only on the accept edge
//   tx_valid  in   sender has a byte; held high until accepted
//   tx_ready  out  block can accept a byte (high only while idle)
//   TxD       out  serial line, registered, idles high
//   tx_busy   out  frame in progress (inverse of tx_ready)
//   tx_done   out  one-cycle pulse on the edge the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int clk_freq  = 100_000_000,
  parameter int baud_rate = 9_600,
  parameter int bit_ticks = clk_freq / baud_rate
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  // Counter wide enough to hold bit_ticks-1. bit_ticks below 2 is not
  // supported; the guard keeps the width legal anyway.
  localparam int              CNT_W    = (bit_ticks > 1) ? $clog2(bit_ticks) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bit_ticks - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [CNT_W-1:0] w_baud_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_txd;
  logic             w_txd_next;
  logic             r_ready;
  logic             w_ready_next;
  logic             r_done;
  logic             w_done_next;

  logic             w_bit_end;
  logic             w_accept;

  // The last cycle of the current bit: the next edge starts a new bit.
  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  // r_ready is only high in S_IDLE, so this also implies the idle state.
  assign w_accept  = tx_valid && r_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking would make the result
  // depend on statement order.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_txd      <= w_txd_next;
      r_ready    <= w_ready_next;
      r_done     <= w_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_next    = r_state;
    w_baud_cnt_next = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_txd_next      = r_txd;
    w_ready_next    = r_ready;
    w_done_next     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Counter parked at zero so the start bit gets a full bit_ticks.
        w_baud_cnt_next = '0;
        w_txd_next      = 1'b1;
        if (w_accept) begin
          w_shift_next   = tx_data;
          w_bit_idx_next = '0;
          w_txd_next     = 1'b0;
          w_ready_next   = 1'b0;
          w_state_next   = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          // Start bit over: present data bit 0 and line up bit 1.
          w_txd_next     = r_shift[0];
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_txd_next   = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_txd_next     = r_shift[0];
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        w_txd_next = 1'b1;
        if (w_bit_end) begin
          // Ready rises with done; the earliest next accept is one edge
          // later, which guarantees an idle-high cycle between frames.
          w_ready_next = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_baud_cnt_next = '0;
        w_txd_next      = 1'b1;
        w_ready_next    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from registers
  // ---------------------------------------------------------------------------
  assign TxD      = r_txd;
  assign tx_ready = r_ready;
  assign tx_busy  = ~r_ready;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//   Scoreboard bench for uart_tx_framer with bit_ticks = 10. The driver pushes
//   one expected frame per byte it offers. The monitor waits for a start bit,
//   pops the oldest entry and checks every cycle of the frame, the tx_done
//   timing and the back-to-back gap. A reset in mid-frame is expected only when
//   the entry says so.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int BT        = CLK_FREQ / BAUD_RATE;  // 10 cycles per bit

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TxD;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_framer #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD_RATE)
  ) dut (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .TxD      (TxD),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct {
    logic [7:0] data;
    bit         b2b;    // starts one cycle after the previous tx_done
    bit         abort;  // a reset cuts this frame short
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   mon_busy = 1'b0;

  always @(posedge clk_fpga) cyc <= cyc + 1;
  always @(negedge clk_fpga) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: all sampling on the falling edge
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t       e;
    int         budget;
    int         s;
    int         last_done;
    logic [9:0] bits;
    logic       got_b;
    bit         bit_bad;
    bit         hs_bad;
    bit         aborted;

    last_done = -1000;
    @(negedge clk_fpga);
    forever begin
      if (sb_q.size() == 0) begin
        if (reset === 1'b0 && TxD === 1'b0) begin
          check("unexpected_start", TxD, 1'b1);
          budget = 200;
          while (TxD === 1'b0 && budget > 0) begin
            @(negedge clk_fpga);
            budget--;
          end
        end
        @(negedge clk_fpga);
        continue;
      end

      e        = sb_q.pop_front();
      mon_busy = 1'b1;
      budget   = 300;
      while ((TxD !== 1'b0 || reset !== 1'b0) && budget > 0) begin
        @(negedge clk_fpga);
        budget--;
      end
      check($sformatf("start_seen_%02h", e.data), (budget > 0), 1'b1);
      if (budget == 0) begin
        mon_busy = 1'b0;
        continue;
      end

      s = cyc;
      check("start_ready_low", tx_ready, 1'b0);
      check("start_busy_high", tx_busy, 1'b1);
      if (e.b2b) check("b2b_gap_cycles", s - last_done, 1);

      bits    = {1'b1, e.data, 1'b0};
      aborted = 1'b0;
      hs_bad  = 1'b0;
      bit_bad = 1'b0;
      got_b   = 1'b0;
      for (int k = 0; k < 10 * BT; k++) begin
        if (k > 0) @(negedge clk_fpga);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (k % BT == 0) begin
          bit_bad = 1'b0;
          got_b   = bits[k / BT];
        end
        if (TxD !== bits[k / BT] && !bit_bad) begin
          bit_bad = 1'b1;
          got_b   = TxD;
        end
        if (tx_done !== 1'b0 || tx_ready !== 1'b0) hs_bad = 1'b1;
        if (k % BT == BT - 1)
          check($sformatf("frame_%02h_bit%0d", e.data, k / BT), got_b, bits[k / BT]);
      end

      check($sformatf("abort_match_%02h", e.data), aborted, e.abort);
      if (aborted) begin
        check("abort_txd_high", TxD, 1'b1);
        check("abort_ready_high", tx_ready, 1'b1);
        check("abort_busy_low", tx_busy, 1'b0);
        check("abort_no_done", tx_done, 1'b0);
        budget = 200;
        while (reset !== 1'b0 && budget > 0) begin
          @(negedge clk_fpga);
          if (tx_done !== 1'b0) hs_bad = 1'b1;
          budget--;
        end
        check("abort_quiet_flags", hs_bad, 1'b0);
      end else begin
        check("frame_flags_quiet", hs_bad, 1'b0);
        @(negedge clk_fpga);
        check("done_latency", cyc - s, 10 * BT);
        check("done_pulse", tx_done, 1'b1);
        check("done_ready_high", tx_ready, 1'b1);
        check("done_busy_low", tx_busy, 1'b0);
        check("done_txd_high", TxD, 1'b1);
        last_done = cyc;
        @(negedge clk_fpga);
        check("done_one_cycle", tx_done, 1'b0);
      end
      mon_busy = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic send_one(input logic [7:0] d, input bit abort);
    exp_t e;
    @(negedge clk_fpga);
    tx_data  = d;
    tx_valid = 1'b1;
    e.data   = d;
    e.b2b    = 1'b0;
    e.abort  = abort;
    sb_q.push_back(e);
    if (!abort) exp_done++;
    @(negedge clk_fpga);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy || tx_ready !== 1'b1) && n < 1000) begin
      @(negedge clk_fpga);
      n++;
    end
    check("wait_idle_in_time", (n < 1000), 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    exp_t e;
    int   bad;
    int   n;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(negedge clk_fpga);
    check("rst_txd", TxD, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    #1 reset = 1'b0;

    // Idle for 50 cycles with tx_valid low: outputs must not move.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_fpga);
      if (TxD !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_stable_bad_samples", bad, 0);

    // Single byte with a one-cycle valid: 0,1,0,1,0,0,1,0,1,1.
    send_one(8'hA5, 1'b0);
    wait_idle();

    // 0x00 then 0xFF with tx_valid held high across both frames.
    @(negedge clk_fpga);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    e.data = 8'h00; e.b2b = 1'b0; e.abort = 1'b0;
    sb_q.push_back(e);
    e.data = 8'hFF; e.b2b = 1'b1; e.abort = 1'b0;
    sb_q.push_back(e);
    exp_done += 2;
    @(negedge clk_fpga);
    tx_data = 8'hFF;
    n = 0;
    while (tx_done !== 1'b1 && n < 300) begin
      @(negedge clk_fpga);
      n++;
    end
    check("first_done_in_time", (n < 300), 1'b1);
    @(negedge clk_fpga);
    tx_valid = 1'b0;
    wait_idle();

    // 0x3C, then tx_data and a stray tx_valid pulse while busy: both ignored.
    send_one(8'h3C, 1'b0);
    repeat (30) @(negedge clk_fpga);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk_fpga);
    tx_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk_fpga);

    // Reset in the middle of data bit 3, then a clean 0x5A.
    send_one(8'h96, 1'b1);
    repeat (45) @(negedge clk_fpga);
    #1 reset = 1'b1;
    #1;
    check("async_rst_txd", TxD, 1'b1);
    check("async_rst_ready", tx_ready, 1'b1);
    check("async_rst_busy", tx_busy, 1'b0);
    repeat (5) @(negedge clk_fpga);
    #1 reset = 1'b0;
    wait_idle();
    send_one(8'h5A, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk_fpga);

    check("done_pulse_count", done_cnt, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
